guess_game_ctrl: RTL and testbench

- Game sequencer for the 3-digit guess-and-check game.
- Generates a target, collects player digit entry, and drives the digit checker's start_check / input_number / target_number.
- Decodes the checker's 6-bit result, counts attempts, runs a countdown timer, and declares win or lose.
- Sits between the keypad/button front-end and the checker; its outputs also feed the display/LED logic.

---
 rtl/guess_game_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Game sequencer for the 3-digit guess-and-check game: target generation, digit
// entry, checker handshake, attempt counting, countdown timer and win/lose.
module guess_game_ctrl #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned TIME_LIMIT   = 60,
    parameter int unsigned MAX_ATTEMPTS = 8,
    parameter logic [11:0] LFSR_SEED    = 12'hACE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        digit_valid,
    input  logic [3:0]  digit_in,
    input  logic        btn_delete,
    input  logic        btn_submit,
    input  logic        fixed_en,
    input  logic [11:0] fixed_target,
    input  logic [5:0]  check_result,
    output logic        start_check,
    output logic [11:0] input_number,
    output logic [11:0] target_number,
    output logic [3:0]  attempts,
    output logic [7:0]  time_left,
    output logic [1:0]  digit_count,
    output logic [1:0]  last_exact,
    output logic [1:0]  last_misplaced,
    output logic [2:0]  game_state,
    output logic        win,
    output logic        lose
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        INPUT = 3'd2,
        CHECK = 3'd3,
        JUDGE = 3'd4,
        WIN   = 3'd5,
        LOSE  = 3'd6
    } state_t;

    localparam int unsigned PRE_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ - 1);
    localparam logic [7:0] TL_INIT  = 8'(TIME_LIMIT);
    localparam logic [3:0] ATT_MAX  = 4'(MAX_ATTEMPTS);

    state_t            state;
    logic [11:0]       lfsr;
    logic [PRE_W-1:0]  presc;
    logic              chk_phase;
    logic [11:0]       candidate;
    logic              cand_ok;
    logic              timed;

    // One-hot-ish checker code to a count; any malformed code reads as zero.
    function automatic logic [1:0] decode_code(input logic [2:0] code);
        logic [1:0] n;
        case (code)
            3'b100:  n = 2'd3;
            3'b010:  n = 2'd2;
            3'b001:  n = 2'd1;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic target_ok(input logic [11:0] v);
        logic [3:0] a, b, c;
        a = v[11:8];
        b = v[7:4];
        c = v[3:0];
        return (a <= 4'd9) && (b <= 4'd9) && (c <= 4'd9) &&
               (a != b) && (a != c) && (b != c);
    endfunction

    assign candidate  = fixed_en ? fixed_target : lfsr;
    assign cand_ok    = target_ok(candidate);
    assign timed      = (state == INPUT) || (state == CHECK) || (state == JUDGE);
    assign game_state = state;

    // Free-running target source, taps 12,6,4,1.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            start_check    <= 1'b0;
            chk_phase      <= 1'b0;
            input_number   <= 12'h000;
            target_number  <= 12'h000;
            attempts       <= 4'd0;
            time_left      <= TL_INIT;
            digit_count    <= 2'd0;
            last_exact     <= 2'd0;
            last_misplaced <= 2'd0;
            presc          <= '0;
            win            <= 1'b0;
            lose           <= 1'b0;
        end else if (btn_start) begin
            // Restart from anywhere; an in-flight check is simply abandoned.
            state       <= GEN;
            start_check <= 1'b0;
            chk_phase   <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            if (timed) begin
                if (presc == PRE_MAX) begin
                    presc <= '0;
                    if (time_left != 8'd0)
                        time_left <= time_left - 8'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                end

                GEN: begin
                    if (cand_ok) begin
                        target_number  <= candidate;
                        attempts       <= 4'd0;
                        time_left      <= TL_INIT;
                        input_number   <= 12'h000;
                        digit_count    <= 2'd0;
                        last_exact     <= 2'd0;
                        last_misplaced <= 2'd0;
                        presc          <= '0;
                        state          <= INPUT;
                    end
                end

                INPUT: begin
                    if (time_left == 8'd0) begin
                        state <= LOSE;
                        lose  <= 1'b1;
                    end else if (btn_submit) begin
                        if (digit_count == 2'd3) begin
                            state       <= CHECK;
                            start_check <= 1'b1;
                            chk_phase   <= 1'b0;
                        end
                    end else if (btn_delete) begin
                        if (digit_count != 2'd0) begin
                            input_number <= {4'h0, input_number[11:4]};
                            digit_count  <= digit_count - 2'd1;
                        end
                    end else if (digit_valid) begin
                        if ((digit_count != 2'd3) && (digit_in <= 4'd9)) begin
                            input_number <= {input_number[7:0], digit_in};
                            digit_count  <= digit_count + 2'd1;
                        end
                    end
                end

                // First cycle lets the checker latch; result is taken on the second.
                CHECK: begin
                    if (!chk_phase) begin
                        chk_phase <= 1'b1;
                    end else begin
                        chk_phase      <= 1'b0;
                        start_check    <= 1'b0;
                        last_exact     <= decode_code(check_result[5:3]);
                        last_misplaced <= decode_code(check_result[2:0]);
                        attempts       <= attempts + 4'd1;
                        state          <= JUDGE;
                    end
                end

                JUDGE: begin
                    if (last_exact == 2'd3) begin
                        state <= WIN;
                        win   <= 1'b1;
                    end else if ((attempts == ATT_MAX) || (time_left == 8'd0)) begin
                        state <= LOSE;
                        lose  <= 1'b1;
                    end else begin
                        input_number <= 12'h000;
                        digit_count  <= 2'd0;
                        state        <= INPUT;
                    end
                end

                WIN, LOSE: begin
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Bench for guess_game_ctrl: directed game scenarios, a cycle-level game model
// compared on every cycle, and literal spot checks on key outcomes.
module tb_guess_game_ctrl;

    localparam int CLK_FREQ     = 10;
    localparam int TIME_LIMIT   = 3;
    localparam int MAX_ATTEMPTS = 2;
    localparam logic [11:0] SEED = 12'hACE;

    localparam int S_IDLE = 0, S_GEN = 1, S_INPUT = 2, S_CHECK = 3;
    localparam int S_JUDGE = 4, S_WIN = 5, S_LOSE = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit_in = 4'd0;
    logic        btn_delete = 1'b0;
    logic        btn_submit = 1'b0;
    logic        fixed_en = 1'b1;
    logic [11:0] fixed_target = 12'h123;
    logic [5:0]  check_result = 6'd0;
    logic        start_check;
    logic [11:0] input_number;
    logic [11:0] target_number;
    logic [3:0]  attempts;
    logic [7:0]  time_left;
    logic [1:0]  digit_count;
    logic [1:0]  last_exact;
    logic [1:0]  last_misplaced;
    logic [2:0]  game_state;
    logic        win;
    logic        lose;

    guess_game_ctrl #(
        .CLK_FREQ(CLK_FREQ), .TIME_LIMIT(TIME_LIMIT),
        .MAX_ATTEMPTS(MAX_ATTEMPTS), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .digit_valid(digit_valid),
        .digit_in(digit_in), .btn_delete(btn_delete), .btn_submit(btn_submit),
        .fixed_en(fixed_en), .fixed_target(fixed_target), .check_result(check_result),
        .start_check(start_check), .input_number(input_number),
        .target_number(target_number), .attempts(attempts), .time_left(time_left),
        .digit_count(digit_count), .last_exact(last_exact),
        .last_misplaced(last_misplaced), .game_state(game_state), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: digits kept as a list, time as elapsed timed cycles.
    int m_st = S_IDLE, m_sc = 0, m_target = 0, m_att = 0, m_ticks = 0;
    int m_exact = 0, m_mis = 0, m_cphase = 0, m_lfsr = int'(SEED);
    int m_cand, m_tl, m_in;
    int digits[$];

    function automatic int secs_left(input int ticks);
        int s;
        s = TIME_LIMIT - ticks / CLK_FREQ;
        return (s < 0) ? 0 : s;
    endfunction

    function automatic int lfsr_step(input int v);
        int fb;
        fb = ((v >> 11) ^ (v >> 5) ^ (v >> 3) ^ v) & 1;
        return ((v << 1) & 'hFFF) | fb;
    endfunction

    function automatic int count_of(input int code);
        if (code == 4) return 3;
        if (code == 2) return 2;
        if (code == 1) return 1;
        return 0;
    endfunction

    function automatic bit valid_target(input int v);
        int a, b, c;
        a = (v >> 8) & 15; b = (v >> 4) & 15; c = v & 15;
        return a <= 9 && b <= 9 && c <= 9 && a != b && a != c && b != c;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_st = S_IDLE; m_sc = 0; m_target = 0; m_att = 0; m_ticks = 0;
            m_exact = 0; m_mis = 0; m_cphase = 0; m_lfsr = int'(SEED);
            digits.delete();
        end else begin
            m_cand = fixed_en ? int'(fixed_target) : m_lfsr;
            m_tl = secs_left(m_ticks);
            m_lfsr = lfsr_step(m_lfsr);
            if (btn_start) begin
                m_st = S_GEN;
                m_sc = 0;
            end else begin
                if (m_st == S_INPUT || m_st == S_CHECK || m_st == S_JUDGE) m_ticks++;
                case (m_st)
                    S_GEN: if (valid_target(m_cand)) begin
                        m_target = m_cand; m_att = 0; m_ticks = 0;
                        m_exact = 0; m_mis = 0; digits.delete(); m_st = S_INPUT;
                    end
                    S_INPUT: begin
                        if (m_tl == 0) m_st = S_LOSE;
                        else if (btn_submit) begin
                            if (digits.size() == 3) begin m_st = S_CHECK; m_sc = 1; m_cphase = 0; end
                        end else if (btn_delete) begin
                            if (digits.size() > 0) digits.delete(digits.size() - 1);
                        end else if (digit_valid) begin
                            if (digits.size() < 3 && digit_in <= 9) digits.push_back(int'(digit_in));
                        end
                    end
                    S_CHECK: begin
                        if (m_cphase == 0) m_cphase = 1;
                        else begin
                            m_exact = count_of(int'(check_result[5:3]));
                            m_mis = count_of(int'(check_result[2:0]));
                            m_att++; m_sc = 0; m_st = S_JUDGE;
                        end
                    end
                    S_JUDGE: begin
                        if (m_exact == 3) m_st = S_WIN;
                        else if (m_att == MAX_ATTEMPTS || m_tl == 0) m_st = S_LOSE;
                        else begin digits.delete(); m_st = S_INPUT; end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            m_in = 0;
            foreach (digits[i]) m_in = m_in * 16 + digits[i];
            check("game_state", game_state, m_st);
            check("start_check", start_check, m_sc);
            check("input_number", input_number, m_in);
            check("target_number", target_number, m_target);
            check("attempts", attempts, m_att);
            check("time_left", time_left, secs_left(m_ticks));
            check("digit_count", digit_count, digits.size());
            check("last_exact", last_exact, m_exact);
            check("last_misplaced", last_misplaced, m_mis);
            check("win", win, m_st == S_WIN);
            check("lose", lose, m_st == S_LOSE);
        end
    end

    // One-cycle pulse set; called and returning on a falling edge.
    task automatic cyc(input bit s, input bit d, input bit dv, input logic [3:0] dg, input bit st);
        btn_submit = s; btn_delete = d; digit_valid = dv; digit_in = dg; btn_start = st;
        @(negedge clk);
        btn_submit = 0; btn_delete = 0; digit_valid = 0; digit_in = 0; btn_start = 0;
    endtask

    task automatic dig(input logic [3:0] d); cyc(0, 0, 1, d, 0); endtask
    task automatic idle(input int n); repeat (n) @(negedge clk); endtask

    task automatic start_game();
        int n;
        cyc(0, 0, 0, 0, 1);
        n = 0;
        while (game_state !== 3'd2 && n < 3000) begin @(negedge clk); n++; end
        check("gen_timeout", n < 3000, 1);
    endtask

    initial begin : stim
        int sc_cnt;
        @(negedge clk); cmp_en = 1;
        idle(2);
        rst = 0;
        check("rst_state", game_state, S_IDLE);
        check("rst_time", time_left, TIME_LIMIT);
        check("rst_target", target_number, 0);

        // Win path
        fixed_en = 1; fixed_target = 12'h123;
        cyc(0, 0, 0, 0, 1);
        check("gen_state", game_state, S_GEN);
        idle(1);
        check("input_state", game_state, S_INPUT);
        dig(1); dig(2); dig(3);
        check("guess_123", input_number, 12'h123);
        check_result = 6'b100000;
        cyc(1, 0, 0, 0, 0);
        sc_cnt = 0;
        repeat (4) begin if (start_check) sc_cnt++; @(negedge clk); end
        check("start_check_len", sc_cnt, 2);
        check("win_exact", last_exact, 3);
        check("win_attempts", attempts, 1);
        check("win_state", game_state, S_WIN);
        check("win_flag", win, 1);

        // Editing and partial result
        start_game();
        dig(4); dig(5);
        cyc(1, 0, 0, 0, 0);
        check("early_submit", game_state, S_INPUT);
        check("early_count", digit_count, 2);
        cyc(0, 1, 0, 0, 0);
        dig(4'hA);
        check("bad_digit", input_number, 12'h004);
        dig(7); dig(8); dig(9);
        check("edit_number", input_number, 12'h478);
        check("edit_count", digit_count, 3);
        repeat (3) cyc(0, 1, 0, 0, 0);
        dig(1); dig(3); dig(2);
        check_result = 6'b001010;
        cyc(1, 1, 0, 0, 0);
        idle(3);
        check("partial_state", game_state, S_INPUT);
        check("partial_exact", last_exact, 1);
        check("partial_mis", last_misplaced, 2);
        check("partial_clear", input_number, 0);

        // Attempts exhausted
        start_game();
        check_result = 6'b000000;
        repeat (2) begin
            dig(4); dig(5); dig(6);
            cyc(1, 0, 0, 0, 0);
            idle(3);
        end
        check("exh_state", game_state, S_LOSE);
        check("exh_lose", lose, 1);
        check("exh_attempts", attempts, 2);
        dig(7);
        check("exh_frozen", input_number, 12'h456);

        // Timeout with no input
        start_game();
        check("tl3", time_left, 3);
        idle(10); check("tl2", time_left, 2);
        idle(10); check("tl1", time_left, 1);
        idle(10); check("tl0", time_left, 0);
        check("tl0_state", game_state, S_INPUT);
        idle(1);  check("timeout_lose", game_state, S_LOSE);

        // Expiry during CHECK still wins on exact 3
        start_game();
        dig(1); dig(2); dig(3);
        idle(25);
        check_result = 6'b100000;
        cyc(1, 0, 0, 0, 0);
        check("exp_tl1", time_left, 1);
        idle(1);
        check("exp_tl0", time_left, 0);
        check("exp_check", game_state, S_CHECK);
        idle(2);
        check("exp_win", game_state, S_WIN);

        // Abort a check with btn_start
        start_game();
        dig(1); dig(2); dig(3);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        check("abort_state", game_state, S_GEN);
        check("abort_sc", start_check, 0);
        idle(1);

        // GEN filter, then reset in CHECK
        fixed_target = 12'h112;
        cyc(0, 0, 0, 0, 1);
        idle(2);
        check("gen_hold", game_state, S_GEN);
        fixed_target = 12'h907;
        idle(1);
        check("gen_accept", game_state, S_INPUT);
        check("gen_target", target_number, 12'h907);
        dig(9); dig(0); dig(7);
        cyc(1, 0, 0, 0, 0);
        check("pre_rst_check", game_state, S_CHECK);
        rst = 1;
        idle(1);
        rst = 0;
        check("rst2_state", game_state, S_IDLE);
        check("rst2_time", time_left, TIME_LIMIT);
        check("rst2_target", target_number, 0);
        check("rst2_attempts", attempts, 0);
        check("rst2_sc", start_check, 0);

        // LFSR-sourced target
        fixed_en = 0;
        start_game();
        check("lfsr_target_ok", valid_target(int'(target_number)), 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
